// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 command transmitter. It inhibits the bus, drives a start
// bit, and shifts out 8 data bits LSB-first, odd parity and stop, one bit per
// device clock falling edge. It then samples the device ACK and waits for the
// bus to go idle. A watchdog aborts the transfer if the device stops clocking.
// Both pins are open-drain: an *_oe output of 1 pulls the line low.
// INHIBIT_CYCLES and TIMEOUT_CYCLES must both be at least 2.

module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       rst,          // asynchronous, active-low
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_ok,
   output logic       error
);

   // ---------------------------------------------------------------------------
   // Constants
   // ---------------------------------------------------------------------------
   localparam int INH_W = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   // Last inhibit cycle, and the cycle before it (where the start bit is launched
   // so that it is on the line during the final inhibit cycle).
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [INH_W-1:0] INH_DATA = INH_W'(INHIBIT_CYCLES - 2);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_INHIBIT = 3'd1;
   localparam logic [2:0] S_REQ     = 3'd2;
   localparam logic [2:0] S_SEND    = 3'd3;
   localparam logic [2:0] S_ACK     = 3'd4;
   localparam logic [2:0] S_RELEASE = 3'd5;

   // ---------------------------------------------------------------------------
   // Signals
   // ---------------------------------------------------------------------------
   logic [1:0]       clk_sync;
   logic [1:0]       data_sync;
   logic             clk_prev;
   logic             clk_s;
   logic             data_s;
   logic             fall;

   logic [2:0]       state;
   logic [7:0]       shift_reg;
   logic             parity_bit;
   logic [3:0]       bit_cnt;
   logic [INH_W-1:0] inh_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic             ack_bit;
   logic             tmo_run;
   logic             tmo_hit;

   assign clk_s  = clk_sync[1];
   assign data_s = data_sync[1];
   assign fall   = clk_prev & ~clk_s;

   // The watchdog runs whenever the device is expected to make progress.
   assign tmo_run = (state == S_REQ)  || (state == S_SEND) ||
                    (state == S_ACK)  || (state == S_RELEASE);
   // A falling edge in the limit cycle wins: the counter clears and no abort.
   assign tmo_hit = tmo_run && !fall && (tmo_cnt == TMO_LAST);

   assign busy = (state != S_IDLE);

   // Two-stage synchronizers for both pins, plus an edge-detect stage on the clock
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: synchronizers reset to 1 (idle bus level) so that leaving reset
         // never produces a false falling edge.
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
         clk_prev  <= 1'b1;
      end else begin
         // NOTE: every register in an always_ff uses <=, so all of them update
         // together from the values that were current before the edge.
         clk_sync  <= {clk_sync[0], ps2_clk_in};
         data_sync <= {data_sync[0], ps2_data_in};
         clk_prev  <= clk_s;
      end
   end

   // Transfer sequencer: inhibit, request, bit shifting, ACK, release, watchdog
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         shift_reg   <= 8'h00;
         parity_bit  <= 1'b0;
         bit_cnt     <= 4'd0;
         inh_cnt     <= '0;
         tmo_cnt     <= '0;
         ack_bit     <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         done        <= 1'b0;
         ack_ok      <= 1'b0;
         error       <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;

         if (tmo_hit) begin
            // Device went silent: free both lines and report a failed transfer.
            state       <= S_IDLE;
            tmo_cnt     <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b1;
            error       <= 1'b1;
            ack_ok      <= 1'b0;
         end else begin
            if (tmo_run) begin
               tmo_cnt <= fall ? '0 : tmo_cnt + TMO_W'(1);
            end

            case (state)
               S_IDLE: begin
                  if (tx_start) begin
                     shift_reg  <= tx_data;
                     parity_bit <= ~^tx_data;
                     ack_ok     <= 1'b0;
                     inh_cnt    <= '0;
                     ps2_clk_oe <= 1'b1;
                     state      <= S_INHIBIT;
                  end
               end

               S_INHIBIT: begin
                  inh_cnt <= inh_cnt + INH_W'(1);
                  if (inh_cnt == INH_DATA) begin
                     ps2_data_oe <= 1'b1;          // start bit
                  end
                  if (inh_cnt == INH_LAST) begin
                     ps2_clk_oe  <= 1'b0;          // hand the clock to the device
                     ps2_data_oe <= 1'b1;
                     bit_cnt     <= 4'd0;
                     tmo_cnt     <= '0;
                     state       <= S_REQ;
                  end
               end

               S_REQ: begin
                  if (fall) begin
                     ps2_data_oe <= ~shift_reg[0];
                     shift_reg   <= {1'b0, shift_reg[7:1]};
                     bit_cnt     <= 4'd1;
                     state       <= S_SEND;
                  end
               end

               S_SEND: begin
                  if (fall) begin
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt < 4'd8) begin
                        ps2_data_oe <= ~shift_reg[0];
                        shift_reg   <= {1'b0, shift_reg[7:1]};
                     end else if (bit_cnt == 4'd8) begin
                        ps2_data_oe <= ~parity_bit;
                     end else begin
                        ps2_data_oe <= 1'b0;       // stop bit: release data
                        state       <= S_ACK;
                     end
                  end
               end

               S_ACK: begin
                  if (fall) begin
                     ack_bit <= ~data_s;           // device pulls data low to ACK
                     bit_cnt <= bit_cnt + 4'd1;
                     state   <= S_RELEASE;
                  end
               end

               S_RELEASE: begin
                  if (clk_s && data_s) begin
                     done   <= 1'b1;
                     ack_ok <= ack_bit;
                     state  <= S_IDLE;
                  end
               end

               default: begin
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  state       <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule
